ps2_key_decoder: RTL and testbench

//  Scan-code decoder between ps2_keyboard (byte FIFO) and the display/seg/LED logic in top.

---
 rtl/ps2_key_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops bytes from the ps2_keyboard FIFO and parses PS/2 set-2
// scan-code sequences (E0 extended prefix, F0 break prefix) into one-cycle key
// events. It tracks the held key and counts distinct presses.
// Optional feature: define KBD_ASCII_EN to build the scan-code to ASCII lookup;
// without it key_ascii is tied to 8'h00.
module ps2_key_decoder #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_break,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_held,
  output logic [CNT_W-1:0] key_count,
  output logic             ovf_sticky
);

  // The prefix timeout counter runs 0 .. TIMEOUT_CYC-1 and fires on the last value
  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_DEC
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             pop_n_next;
  logic             capture_en;
  logic             decode_en;

  logic [7:0]       byte_r;
  logic             ext_r;
  logic             brk_r;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       held_code;
  logic             held_ext;

  logic             is_e0;
  logic             is_f0;
  logic             is_prefix;
  logic             held_match;
  logic             ev_release;
  logic             ev_press;
  logic             tmo_hit;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a byte takes one cycle each in IDLE, POP and DEC
  always_comb begin
    state_next = state;
    pop_n_next = 1'b1;
    capture_en = 1'b0;
    decode_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ready) begin
          capture_en = 1'b1;
          pop_n_next = 1'b0;
          state_next = S_POP;
        end
      end
      S_POP: begin
        state_next = S_DEC;
      end
      S_DEC: begin
        decode_en  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Classify the captured byte against the prefix flags and the held key
  always_comb begin
    is_e0      = (byte_r == 8'hE0);
    is_f0      = (byte_r == 8'hF0);
    is_prefix  = is_e0 | is_f0;
    held_match = key_held && (held_code == byte_r) && (held_ext == ext_r);
    ev_release = decode_en && !is_prefix && brk_r;
    ev_press   = decode_en && !is_prefix && !brk_r && !held_match;
    tmo_hit    = (ext_r | brk_r) && (tmo_cnt == TMO_LAST);
  end

  // Handshake, prefix tracking, event outputs, held key and press counter
  always_ff @(posedge clk) begin
    if (rst) begin
      nextdata_n <= 1'b1;
      key_valid  <= 1'b0;
      key_code   <= 8'h00;
      key_break  <= 1'b0;
      key_ext    <= 1'b0;
      key_held   <= 1'b0;
      key_count  <= '0;
      ovf_sticky <= 1'b0;
      byte_r     <= 8'h00;
      ext_r      <= 1'b0;
      brk_r      <= 1'b0;
      tmo_cnt    <= '0;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
    end else begin
      nextdata_n <= pop_n_next;
      key_valid  <= ev_release | ev_press;
      if (overflow) begin
        ovf_sticky <= 1'b1;
      end
      if (capture_en) begin
        byte_r <= data;
      end
      if (decode_en) begin
        tmo_cnt <= '0;
        if (is_e0) begin
          ext_r <= 1'b1;
        end else if (is_f0) begin
          brk_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
        if (ev_release || ev_press) begin
          key_code  <= byte_r;
          key_break <= ev_release;
          key_ext   <= ext_r;
        end
        if (ev_release && held_match) begin
          key_held <= 1'b0;
        end
        if (ev_press) begin
          held_code <= byte_r;
          held_ext  <= ext_r;
          key_held  <= 1'b1;
          key_count <= key_count + CNT_W'(1);
        end
      end else if (ext_r | brk_r) begin
        if (tmo_hit) begin
          ext_r   <= 1'b0;
          brk_r   <= 1'b0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

`ifdef KBD_ASCII_EN
  // Set-2 scan code to ASCII; extended codes have no ASCII meaning
  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
        8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
        8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
        8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
        8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
        8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
        8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
        8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
        8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
        8'h3E: a = 8'h38;  8'h46: a = 8'h39;
        8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  // ASCII output is registered alongside the other event fields
  always_ff @(posedge clk) begin
    if (rst) begin
      key_ascii <= 8'h00;
    end else if (ev_release || ev_press) begin
      key_ascii <= ascii_of(byte_r, ext_r);
    end
  end
`else
  assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed tests for ps2_key_decoder with a small FIFO model
// standing in for ps2_keyboard. Built with CNT_W=2 so the press counter wraps.
module tb_ps2_key_decoder;

  localparam int CNT_W = 2;
  localparam int TMO   = 20;
`ifdef KBD_ASCII_EN
  localparam bit ASC = 1'b1;
`else
  localparam bit ASC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       data = 8'h00;
  logic             ready = 1'b0;
  logic             overflow = 1'b0;
  logic             nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_break;
  logic             key_ext;
  logic [7:0]       key_ascii;
  logic             key_held;
  logic [CNT_W-1:0] key_count;
  logic             ovf_sticky;

  logic [7:0] fifo[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  int ev_total = 0;
  int valid_dbl = 0;
  int pop_dbl = 0;
  bit prev_valid = 1'b0;
  bit prev_low = 1'b0;
  logic [7:0] ev_code[64];
  logic [7:0] ev_asc[64];
  bit         ev_brk[64];
  bit         ev_ext[64];

  ps2_key_decoder #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_break(key_break), .key_ext(key_ext), .key_ascii(key_ascii),
    .key_held(key_held), .key_count(key_count), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  // FIFO model: pop on a sampled low strobe, then present the new head
  always @(posedge clk) begin
    if (!rst && !nextdata_n && fifo.size() != 0) begin
      fifo.delete(0);
      popped++;
    end
    #1;
    ready = (fifo.size() != 0);
    data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // Event log and pulse-width tracking, sampled mid-cycle
  always @(negedge clk) begin
    if (key_valid) begin
      if (prev_valid) valid_dbl++;
      ev_code[ev_total % 64] = key_code;
      ev_asc[ev_total % 64]  = key_ascii;
      ev_brk[ev_total % 64]  = key_break;
      ev_ext[ev_total % 64]  = key_ext;
      ev_total++;
    end
    prev_valid = key_valid;
    if (!nextdata_n && prev_low) pop_dbl++;
    prev_low = !nextdata_n;
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    pushed++;
  endtask

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (fifo.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: fifo still holds %0d bytes, required 0", fifo.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({nextdata_n, key_valid, key_break, key_ext, key_held, ovf_sticky} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b required 100000",
               {nextdata_n, key_valid, key_break, key_ext, key_held, ovf_sticky});
    end
    checks++;
    if ({key_code, key_ascii} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_code: got %h required 0000", {key_code, key_ascii});
    end
    checks++;
    if (key_count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d required 0", key_count);
    end
  endtask

  task automatic test_latency();
    int t = -1;
    int n = 0;
    do_reset();
    push(8'h1C);
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (ready && t < 0) t = n;
      if (key_valid) break;
    end
    checks++;
    if (!key_valid || t < 0 || (n - t) !== 3) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles (valid=%b) required 3", n - t, key_valid);
    end
    drain();
  endtask

  task automatic test_make_break();
    int b;
    do_reset();
    b = ev_total;
    push(8'h15);
    drain();
    checks++;
    if (ev_total - b !== 1) begin
      errors++;
      $display("[TB] FAIL mb_press_events: got %0d required 1", ev_total - b);
    end
    checks++;
    if ({ev_code[b % 64], ev_brk[b % 64], ev_ext[b % 64]} !== {8'h15, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mb_press_fields: got code=%h brk=%b ext=%b required 15/0/0",
               ev_code[b % 64], ev_brk[b % 64], ev_ext[b % 64]);
    end
    checks++;
    if (ev_asc[b % 64] !== (ASC ? 8'h71 : 8'h00)) begin
      errors++;
      $display("[TB] FAIL mb_press_ascii: got %h required %h", ev_asc[b % 64], ASC ? 8'h71 : 8'h00);
    end
    checks++;
    if ({key_held, key_count} !== {1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL mb_press_state: got held=%b count=%0d required 1/1", key_held, key_count);
    end
    push(8'hF0);
    push(8'h15);
    drain();
    checks++;
    if (ev_total - b !== 2 || ev_code[(b + 1) % 64] !== 8'h15 || ev_brk[(b + 1) % 64] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mb_release: got events=%0d code=%h brk=%b required 2/15/1",
               ev_total - b, ev_code[(b + 1) % 64], ev_brk[(b + 1) % 64]);
    end
    checks++;
    if ({key_held, key_count, key_break} !== {1'b0, 2'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mb_release_state: got held=%b count=%0d brk=%b required 0/1/1",
               key_held, key_count, key_break);
    end
  endtask

  task automatic test_typematic();
    int b;
    do_reset();
    b = ev_total;
    push(8'h15); push(8'h15); push(8'h15); push(8'hF0); push(8'h15);
    drain();
    checks++;
    if (ev_total - b !== 2) begin
      errors++;
      $display("[TB] FAIL typ_events: got %0d required 2", ev_total - b);
    end
    checks++;
    if ({ev_brk[b % 64], ev_brk[(b + 1) % 64]} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL typ_order: got brk seq %b%b required 01", ev_brk[b % 64], ev_brk[(b + 1) % 64]);
    end
    checks++;
    if ({key_held, key_count} !== {1'b0, 2'd1}) begin
      errors++;
      $display("[TB] FAIL typ_state: got held=%b count=%0d required 0/1", key_held, key_count);
    end
  endtask

  task automatic test_extended();
    int b;
    do_reset();
    b = ev_total;
    push(8'hE0); push(8'h75);
    drain();
    checks++;
    if ({ev_code[b % 64], ev_ext[b % 64], ev_brk[b % 64], ev_asc[b % 64]} !== {8'h75, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL ext_press: got code=%h ext=%b brk=%b ascii=%h required 75/1/0/00",
               ev_code[b % 64], ev_ext[b % 64], ev_brk[b % 64], ev_asc[b % 64]);
    end
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ext_held: got %b required 1", key_held);
    end
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    checks++;
    if (ev_total - b !== 2 || {ev_ext[(b + 1) % 64], ev_brk[(b + 1) % 64]} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ext_release: got events=%0d ext=%b brk=%b required 2/1/1",
               ev_total - b, ev_ext[(b + 1) % 64], ev_brk[(b + 1) % 64]);
    end
    checks++;
    if ({key_held, key_count} !== {1'b0, 2'd1}) begin
      errors++;
      $display("[TB] FAIL ext_state: got held=%b count=%0d required 0/1", key_held, key_count);
    end
  endtask

  task automatic test_timeout();
    int b;
    do_reset();
    b = ev_total;
    push(8'hF0);
    drain();
    repeat (TMO + 1) @(negedge clk);
    checks++;
    if (ev_total - b !== 0) begin
      errors++;
      $display("[TB] FAIL tmo_no_event: got %0d events required 0", ev_total - b);
    end
    push(8'h23);
    drain();
    checks++;
    if ({ev_code[b % 64], ev_brk[b % 64]} !== {8'h23, 1'b0}) begin
      errors++;
      $display("[TB] FAIL tmo_press: got code=%h brk=%b required 23/0", ev_code[b % 64], ev_brk[b % 64]);
    end
    checks++;
    if (ev_asc[b % 64] !== (ASC ? 8'h64 : 8'h00)) begin
      errors++;
      $display("[TB] FAIL tmo_ascii: got %h required %h", ev_asc[b % 64], ASC ? 8'h64 : 8'h00);
    end
    do_reset();
    b = ev_total;
    push(8'hF0);
    drain();
    repeat (TMO - 12) @(negedge clk);
    push(8'h15);
    drain();
    checks++;
    if (ev_total - b !== 1 || ev_brk[b % 64] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_early_release: got events=%0d brk=%b required 1/1", ev_total - b, ev_brk[b % 64]);
    end
  endtask

  task automatic test_overflow_reset();
    int n = 0;
    do_reset();
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got %b required 1", ovf_sticky);
    end
    push(8'h15);
    drain();
    push(8'h1D);
    while (nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (nextdata_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_pop_wait: nextdata_n got %b required 0", nextdata_n);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({nextdata_n, key_valid, key_held, ovf_sticky, key_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL rst_in_pop: got ndn=%b valid=%b held=%b ovf=%b count=%0d required 1/0/0/0/0",
               nextdata_n, key_valid, key_held, ovf_sticky, key_count);
    end
    @(negedge clk);
    rst = 1'b0;
    drain();
    checks++;
    if ({key_code, key_held, key_count} !== {8'h1D, 1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL rst_byte_kept: got code=%h held=%b count=%0d required 1D/1/1",
               key_code, key_held, key_count);
    end
  endtask

  task automatic test_count_wrap();
    logic [7:0]       codes[5];
    logic [CNT_W-1:0] exp_cnt[5];
    codes   = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(codes[i]);
      drain();
      checks++;
      if (key_count !== exp_cnt[i]) begin
        errors++;
        $display("[TB] FAIL count_wrap_%0d: got %0d required %0d", i, key_count, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    checks++;
    if (valid_dbl !== 0) begin
      errors++;
      $display("[TB] FAIL valid_pulse_width: got %0d double pulses required 0", valid_dbl);
    end
    checks++;
    if (pop_dbl !== 0) begin
      errors++;
      $display("[TB] FAIL pop_width: got %0d long strobes required 0", pop_dbl);
    end
    checks++;
    if (popped !== pushed) begin
      errors++;
      $display("[TB] FAIL pop_count: got %0d pops required %0d", popped, pushed);
    end
  endtask

  initial begin
    $display("[TB] ps2_key_decoder test start");
    test_reset();
    test_latency();
    test_make_break();
    test_typematic();
    test_extended();
    test_timeout();
    test_overflow_reset();
    test_count_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
